// File: rtl/uart_rx_tx.sv
// uart_rx_tx -- full-duplex 8N1-style UART (receiver + transmitter).
//
// Purpose:
//   Receiver deserialises uart_rxd into parallel words with a one-cycle valid
//   strobe and detects BREAK frames. Transmitter serialises a parallel word onto
//   uart_txd using an enable/busy handshake. Both halves share clk/resetn and
//   are otherwise independent.
//
// Ports:
//   clk            in   system clock, rising edge
//   resetn         in   synchronous, active-low reset
//   uart_rxd       in   serial input (asynchronous, idle high)
//   uart_rx_en     in   1 = receiver enabled, 0 = receiver held idle
//   uart_rx_break  out  1-cycle pulse on a received BREAK frame
//   uart_rx_valid  out  1-cycle pulse, uart_rx_data holds a new word
//   uart_rx_data   out  last received word, held until the next valid
//   uart_txd       out  serial output (registered, idle high)
//   uart_tx_en     in   send request, level, sampled while not busy
//   uart_tx_busy   out  1 while a frame is being sent
//   uart_tx_data   in   word to send, captured when the request is accepted
module uart_rx_tx #(
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int CLK_HZ       = 12_000_000,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_break,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_txd,
  input  logic                    uart_tx_en,
  output logic                    uart_tx_busy,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data
);

  // Clock cycles per serial bit.
  localparam int CPB = CLK_HZ / BIT_RATE;
  localparam int CW  = $clog2(CPB + 1);
  // Bit index counter covers both the data bits and the stop bits.
  localparam int BW  = $clog2(PAYLOAD_BITS + STOP_BITS + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CPB / 2);
  localparam logic [BW-1:0] DATA_LAST = BW'(PAYLOAD_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic [1:0]              rxd_sync_reg;
  logic                    rxd_prev_reg;
  logic                    rxd_sync;
  logic                    rx_fall;

  state_t                  rx_state_reg, rx_state_next;
  logic [CW-1:0]           rx_cnt_reg, rx_cnt_next;
  logic [BW-1:0]           rx_bit_reg, rx_bit_next;
  logic [PAYLOAD_BITS-1:0] rx_shift_reg, rx_shift_next;
  logic [PAYLOAD_BITS-1:0] rx_data_reg, rx_data_next;
  logic                    rx_valid_reg, rx_valid_next;
  logic                    rx_break_reg, rx_break_next;
  logic [PAYLOAD_BITS:0]   rx_shift_in;

  assign rxd_sync = rxd_sync_reg[1];
  // Start-bit edge seen on the synchronised line; gated so a disabled
  // receiver never leaves IDLE.
  assign rx_fall  = uart_rx_en & rxd_prev_reg & ~rxd_sync;

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_cnt_next   = rx_cnt_reg + CW'(1);
    rx_bit_next   = rx_bit_reg;
    rx_shift_next = rx_shift_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = 1'b0;
    rx_break_next = 1'b0;
    // LSB-first: new sample enters at the top and the word shifts right.
    rx_shift_in   = {rxd_sync, rx_shift_reg};

    case (rx_state_reg)
      ST_IDLE: begin
        rx_cnt_next = '0;
        rx_bit_next = '0;
        if (rx_fall) begin
          rx_state_next = ST_START;
        end
      end
      ST_START: begin
        // Mid start bit: a high line here means the edge was a glitch.
        if (rx_cnt_reg == CNT_HALF) begin
          rx_cnt_next   = '0;
          rx_state_next = rxd_sync ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (rx_cnt_reg == CNT_LAST) begin
          rx_cnt_next   = '0;
          rx_shift_next = rx_shift_in[PAYLOAD_BITS:1];
          if (rx_bit_reg == DATA_LAST) begin
            rx_state_next = ST_STOP;
          end else begin
            rx_bit_next = rx_bit_reg + BW'(1);
          end
        end
      end
      ST_STOP: begin
        if (rx_cnt_reg == CNT_LAST) begin
          rx_cnt_next   = '0;
          rx_state_next = ST_IDLE;
          if (rxd_sync) begin
            rx_data_next  = rx_shift_reg;
            rx_valid_next = 1'b1;
          end else if (rx_shift_reg == '0) begin
            rx_break_next = 1'b1;
          end
          // Low stop bit with non-zero data: framing error, dropped.
        end
      end
      default: begin
        rx_state_next = ST_IDLE;
      end
    endcase

    if (!uart_rx_en) begin
      rx_state_next = ST_IDLE;
      rx_data_next  = rx_data_reg;
      rx_valid_next = 1'b0;
      rx_break_next = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  state_t                  tx_state_reg, tx_state_next;
  logic [CW-1:0]           tx_cnt_reg, tx_cnt_next;
  logic [BW-1:0]           tx_bit_reg, tx_bit_next;
  logic [PAYLOAD_BITS-1:0] tx_shift_reg, tx_shift_next;
  logic                    txd_reg, txd_next;
  logic                    tx_busy_reg, tx_busy_next;

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_cnt_next   = tx_cnt_reg + CW'(1);
    tx_bit_next   = tx_bit_reg;
    tx_shift_next = tx_shift_reg;
    txd_next      = txd_reg;
    tx_busy_next  = tx_busy_reg;

    case (tx_state_reg)
      ST_IDLE: begin
        tx_cnt_next  = '0;
        tx_bit_next  = '0;
        txd_next     = 1'b1;
        tx_busy_next = 1'b0;
        if (uart_tx_en) begin
          tx_shift_next = uart_tx_data;
          tx_state_next = ST_START;
          txd_next      = 1'b0;
          tx_busy_next  = 1'b1;
        end
      end
      ST_START: begin
        if (tx_cnt_reg == CNT_LAST) begin
          tx_cnt_next   = '0;
          tx_bit_next   = '0;
          tx_state_next = ST_DATA;
          txd_next      = tx_shift_reg[0];
          tx_shift_next = tx_shift_reg >> 1;
        end
      end
      ST_DATA: begin
        if (tx_cnt_reg == CNT_LAST) begin
          tx_cnt_next = '0;
          if (tx_bit_reg == DATA_LAST) begin
            tx_state_next = ST_STOP;
            tx_bit_next   = '0;
            txd_next      = 1'b1;
          end else begin
            tx_bit_next   = tx_bit_reg + BW'(1);
            txd_next      = tx_shift_reg[0];
            tx_shift_next = tx_shift_reg >> 1;
          end
        end
      end
      ST_STOP: begin
        if (tx_cnt_reg == CNT_LAST) begin
          tx_cnt_next = '0;
          if (tx_bit_reg == STOP_LAST) begin
            tx_state_next = ST_IDLE;
            tx_busy_next  = 1'b0;
            txd_next      = 1'b1;
          end else begin
            tx_bit_next = tx_bit_reg + BW'(1);
          end
        end
      end
      default: begin
        tx_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rxd_sync_reg <= 2'b11;
      rxd_prev_reg <= 1'b1;
      rx_state_reg <= ST_IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      rx_break_reg <= 1'b0;
      tx_state_reg <= ST_IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      txd_reg      <= 1'b1;
      tx_busy_reg  <= 1'b0;
    end else begin
      rxd_sync_reg <= {rxd_sync_reg[0], uart_rxd};
      rxd_prev_reg <= rxd_sync;
      rx_state_reg <= rx_state_next;
      rx_cnt_reg   <= rx_cnt_next;
      rx_bit_reg   <= rx_bit_next;
      rx_shift_reg <= rx_shift_next;
      rx_data_reg  <= rx_data_next;
      rx_valid_reg <= rx_valid_next;
      rx_break_reg <= rx_break_next;
      tx_state_reg <= tx_state_next;
      tx_cnt_reg   <= tx_cnt_next;
      tx_bit_reg   <= tx_bit_next;
      tx_shift_reg <= tx_shift_next;
      txd_reg      <= txd_next;
      tx_busy_reg  <= tx_busy_next;
    end
  end

  assign uart_rx_break = rx_break_reg;
  assign uart_rx_valid = rx_valid_reg;
  assign uart_rx_data  = rx_data_reg;
  assign uart_txd      = txd_reg;
  assign uart_tx_busy  = tx_busy_reg;

endmodule

// File: tb/tb_uart_rx_tx.sv
// tb_uart_rx_tx -- directed self-checking bench for uart_rx_tx at default
// parameters (1250 clocks per bit). Frames are written as 10-bit vectors in
// line order: bit 0 = start bit, bits 1..8 = data LSB first, bit 9 = stop bit.
module tb_uart_rx_tx;

  localparam int CPB = 1250;

  logic       clk;
  logic       resetn;
  logic       uart_rxd;
  logic       uart_rx_en;
  logic       uart_rx_break;
  logic       uart_rx_valid;
  logic [7:0] uart_rx_data;
  logic       uart_txd;
  logic       uart_tx_en;
  logic       uart_tx_busy;
  logic [7:0] uart_tx_data;

  logic       loopback;
  logic       rxd_drv;

  int tests;
  int fails;

  assign uart_rxd = loopback ? uart_txd : rxd_drv;

  uart_rx_tx dut (
    .clk          (clk),
    .resetn       (resetn),
    .uart_rxd     (uart_rxd),
    .uart_rx_en   (uart_rx_en),
    .uart_rx_break(uart_rx_break),
    .uart_rx_valid(uart_rx_valid),
    .uart_rx_data (uart_rx_data),
    .uart_txd     (uart_txd),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_busy (uart_tx_busy),
    .uart_tx_data (uart_tx_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one frame period (10*CPB+1 negedges), starting at the negedge where a
  // TX request was set up. Optionally checks the TX line mid-bit against
  // tx_frame, and optionally drives rx_frame onto rxd_drv. Counts RX pulses.
  task automatic run_frame(input string tag, input bit do_tx, input logic [9:0] tx_frame,
                           input bit tx_hold, input bit do_rx, input logic [9:0] rx_frame,
                           output int n_valid, output int n_break, output logic [7:0] last_data);
    n_valid   = 0;
    n_break   = 0;
    last_data = uart_rx_data;
    for (int k = 1; k <= 10 * CPB + 1; k++) begin
      @(negedge clk);
      if (do_rx) begin
        if (k <= 10 * CPB && (k - 1) % CPB == 0) rxd_drv = rx_frame[(k - 1) / CPB];
        if (k == 10 * CPB + 1) rxd_drv = 1'b1;
      end
      if (do_tx) begin
        if (k == 1) begin
          check({tag, "_busy_rise"}, uart_tx_busy, 1);
          check({tag, "_start_now"}, uart_txd, 0);
          uart_tx_data = ~uart_tx_data;  // must not affect the frame in flight
          if (!tx_hold) uart_tx_en = 1'b0;
        end
        if (k <= 10 * CPB && (k - 1) % CPB == CPB / 2)
          check($sformatf("%s_bit%0d", tag, (k - 1) / CPB), uart_txd, tx_frame[(k - 1) / CPB]);
        if (k == 10 * CPB) check({tag, "_busy_last"}, uart_tx_busy, 1);
        if (k == 10 * CPB + 1) begin
          check({tag, "_busy_fall"}, uart_tx_busy, 0);
          check({tag, "_txd_idle"}, uart_txd, 1);
        end
      end
      if (uart_rx_valid) begin
        n_valid++;
        last_data = uart_rx_data;
      end
      if (uart_rx_break) n_break++;
    end
    $display("[TB] %s: rx_valid=%0d rx_break=%0d rx_data=%02h", tag, n_valid, n_break, last_data);
  endtask

  initial begin
    int         nv;
    int         nb;
    logic [7:0] ld;
    logic [9:0] ff_frame;

    tests        = 0;
    fails        = 0;
    resetn       = 1'b0;
    uart_rx_en   = 1'b1;
    uart_tx_en   = 1'b0;
    uart_tx_data = 8'h00;
    rxd_drv      = 1'b1;
    loopback     = 1'b0;
    ff_frame     = 10'b1111111110;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_txd", uart_txd, 1);
    check("rst_busy", uart_tx_busy, 0);
    check("rst_valid", uart_rx_valid, 0);
    check("rst_break", uart_rx_break, 0);
    check("rst_data", uart_rx_data, 8'h00);
    $display("[TB] reset: txd=%0b busy=%0b valid=%0b break=%0b data=%02h",
             uart_txd, uart_tx_busy, uart_rx_valid, uart_rx_break, uart_rx_data);
    resetn = 1'b1;
    @(negedge clk);

    // Loopback of 8'hA5: line 0,1,0,1,0,0,1,0,1,1
    loopback     = 1'b1;
    uart_tx_data = 8'hA5;
    uart_tx_en   = 1'b1;
    run_frame("lb_a5", 1, 10'b1101001010, 0, 0, 10'h3FF, nv, nb, ld);
    check("lb_a5_nvalid", nv, 1);
    check("lb_a5_data", ld, 8'hA5);
    check("lb_a5_nbreak", nb, 0);

    // Back-to-back 8'h00 then 8'hFF with tx_en held (still looped back)
    uart_tx_data = 8'h00;
    uart_tx_en   = 1'b1;
    run_frame("b2b_00", 1, 10'b1000000000, 1, 0, 10'h3FF, nv, nb, ld);
    check("b2b_00_nvalid", nv, 1);
    check("b2b_00_data", ld, 8'h00);
    run_frame("b2b_ff", 1, 10'b1111111110, 0, 0, 10'h3FF, nv, nb, ld);
    check("b2b_ff_nvalid", nv, 1);
    check("b2b_ff_data", ld, 8'hFF);
    check("b2b_ff_nbreak", nb, 0);

    // TX 8'h41 pulse while a BREAK frame (all zero, stop low) arrives on RX
    loopback     = 1'b0;
    uart_tx_data = 8'h41;
    uart_tx_en   = 1'b1;
    run_frame("tx41_brk", 1, 10'b1010000010, 0, 1, 10'b0000000000, nv, nb, ld);
    check("brk_nbreak", nb, 1);
    check("brk_nvalid", nv, 0);
    check("brk_data_held", uart_rx_data, 8'hFF);

    // 0.3*CPB low glitch on rxd
    rxd_drv = 1'b0;
    repeat (375) @(negedge clk);
    rxd_drv = 1'b1;
    nv = 0;
    nb = 0;
    for (int k = 0; k < 2 * CPB; k++) begin
      @(negedge clk);
      if (uart_rx_valid) nv++;
      if (uart_rx_break) nb++;
    end
    check("glitch_nvalid", nv, 0);
    check("glitch_nbreak", nb, 0);
    $display("[TB] glitch: rx_valid=%0d rx_break=%0d", nv, nb);

    // Reset in the middle of a TX frame (data bit 4) and an RX frame
    uart_tx_data = 8'h41;
    uart_tx_en   = 1'b1;
    nv = 0;
    for (int k = 1; k <= 5 * CPB + CPB / 2 + 1; k++) begin
      @(negedge clk);
      if (k == 1) uart_tx_en = 1'b0;
      if ((k - 1) % CPB == 0) rxd_drv = ff_frame[(k - 1) / CPB];
      if (uart_rx_valid) nv++;
    end
    check("midrst_pre_txd", uart_txd, 0);
    check("midrst_pre_busy", uart_tx_busy, 1);
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_txd", uart_txd, 1);
    check("midrst_busy", uart_tx_busy, 0);
    check("midrst_data", uart_rx_data, 8'h00);
    resetn  = 1'b1;
    rxd_drv = 1'b1;
    nb = 0;
    for (int k = 0; k < 5 * CPB; k++) begin
      @(negedge clk);
      if (uart_rx_valid) nv++;
      if (uart_tx_busy) nb++;
    end
    check("midrst_nvalid", nv, 0);
    check("midrst_busy_cycles", nb, 0);
    $display("[TB] midrst: rx_valid=%0d busy_cycles=%0d txd=%0b", nv, nb, uart_txd);

    // Clean 8'h3C frame after the aborted one
    run_frame("rx_3c", 0, 10'h000, 0, 1, 10'b1001111000, nv, nb, ld);
    check("rx_3c_nvalid", nv, 1);
    check("rx_3c_data", ld, 8'h3C);
    check("rx_3c_nbreak", nb, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
